// File: rtl/vga_timing_pkg.sv
// Shared encodings and mode constants for the VGA timing receiver.
// Holds the FSM state type, the default counter width and standard mode timings.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_TRACK  = 2'd1,
        S_LOCKED = 2'd2
    } rx_state_t;

    localparam int CW_DEFAULT = 12;

    // 800x600@60: h_start counts sync + back porch from the hsync falling sample.
    localparam int SVGA_H_START  = 216;
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_TOTAL  = 1056;
    localparam int SVGA_V_START  = 27;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_TOTAL  = 628;

    // 1280x1024@60
    localparam int SXGA_H_START  = 360;
    localparam int SXGA_H_ACTIVE = 1280;
    localparam int SXGA_H_TOTAL  = 1688;
    localparam int SXGA_V_START  = 41;
    localparam int SXGA_V_ACTIVE = 1024;
    localparam int SXGA_V_TOTAL  = 1066;

    localparam int LOCK_FRAMES_DEFAULT = 2;

endpackage

// File: rtl/vga_sync_edge.sv
// Registered falling-edge detect plus saturating position counter for one sync input.
// With VGA_RX_POLARITY_DETECT_EN the pulse level is inferred from the shorter run length.
module vga_sync_edge
    import vga_timing_pkg::*;
#(
    parameter int CW = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sync,
    input  logic          step,
    input  logic          restart,
    output logic          fall,
    output logic [CW-1:0] pos,
    output logic          saturated,
    output logic          pol_change
);

    localparam logic [CW-1:0] MAX = '1;

    logic sync_q;
    logic pol;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 1'b0;
            pos    <= '0;
        end else begin
            sync_q <= sync;
            if (restart) begin
                pos <= '0;
            end else if (step && (pos != MAX)) begin
                pos <= pos + 1'b1;
            end
        end
    end

    assign saturated = (pos == MAX);
    // Both samples use the same polarity, so a polarity flip never fakes an edge.
    assign fall      = (sync_q ^ pol) & ~(sync ^ pol);

`ifdef VGA_RX_POLARITY_DETECT_EN
    logic [CW-1:0] run;
    logic [CW-1:0] high_len;
    logic [CW-1:0] low_len;
    logic          pol_next;

    always_comb begin
        pol_next = pol;
        if ((high_len != '0) && (low_len != '0) && (high_len != low_len)) begin
            pol_next = (high_len < low_len);
        end
    end

    assign pol_change = (pol_next != pol);

    always_ff @(posedge clk) begin
        if (rst) begin
            run      <= '0;
            high_len <= '0;
            low_len  <= '0;
            pol      <= 1'b0;
        end else begin
            pol <= pol_next;
            if (sync != sync_q) begin
                if (sync_q) begin
                    high_len <= run;
                end else begin
                    low_len <= run;
                end
                run <= '0;
            end else if (step && (run != MAX)) begin
                run <= run + 1'b1;
            end
        end
    end
`else
    assign pol        = 1'b0;
    assign pol_change = 1'b0;
`endif

endmodule

// File: rtl/vga_timing_rx.sv
// VGA timing receiver: measures line/frame period, locks after stable frames, regenerates x/y.
// Optional VGA_RX_POLARITY_DETECT_EN infers sync polarity instead of assuming active-low.
module vga_timing_rx
    import vga_timing_pkg::*;
#(
    parameter int H_START     = SVGA_H_START,
    parameter int H_ACTIVE    = SVGA_H_ACTIVE,
    parameter int V_START     = SVGA_V_START,
    parameter int V_ACTIVE    = SVGA_V_ACTIVE,
    parameter int LOCK_FRAMES = LOCK_FRAMES_DEFAULT,
    parameter int CW          = CW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hsync,
    input  logic          vsync,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          active,
    output logic          locked,
    output logic [CW-1:0] h_total,
    output logic [CW-1:0] v_total
);

    // active is a valid strobe with no back-pressure: x/y are meaningful only
    // in cycles where active is high and are held at 0 otherwise.

    localparam int LCW = $clog2(LOCK_FRAMES + 1);

    rx_state_t     state;
    rx_state_t     state_next;
    logic [LCW-1:0] lock_cnt;
    logic [LCW-1:0] lock_cnt_next;
    logic [LCW-1:0] lock_cnt_inc;

    logic          hs_fall;
    logic          vs_fall;
    logic [CW-1:0] h_pos;
    logic [CW-1:0] v_pos;
    logic          h_sat;
    logic          v_sat;
    logic          h_pol_change;
    logic          v_pol_change;

    logic          vs_pend;
    logic          bad_acc;
    logic          ref_valid;

    logic          frame_start;
    logic          v_restart;
    logic [CW-1:0] h_pos_inc;
    logic [CW-1:0] v_pos_inc;
    logic          line_bad;
    logic          v_match;
    logic          frame_ok;
    logic          in_window;

    assign frame_start = hs_fall & (vs_pend | vs_fall);
    assign v_restart   = frame_start;

    vga_sync_edge #(.CW(CW)) u_hsync (
        .clk        (clk),
        .rst        (rst),
        .sync       (hsync),
        .step       (1'b1),
        .restart    (hs_fall),
        .fall       (hs_fall),
        .pos        (h_pos),
        .saturated  (h_sat),
        .pol_change (h_pol_change)
    );

    // The vertical counter advances in line units: one step per hsync edge.
    vga_sync_edge #(.CW(CW)) u_vsync (
        .clk        (clk),
        .rst        (rst),
        .sync       (vsync),
        .step       (hs_fall),
        .restart    (v_restart),
        .fall       (vs_fall),
        .pos        (v_pos),
        .saturated  (v_sat),
        .pol_change (v_pol_change)
    );

    assign h_pos_inc = h_sat ? h_pos : (h_pos + 1'b1);
    assign v_pos_inc = v_sat ? v_pos : (v_pos + 1'b1);
    assign line_bad  = hs_fall & (h_pos_inc != h_total);
    // The first complete frame after SEARCH has no trustworthy reference length.
    assign v_match   = ~ref_valid | (v_pos_inc == v_total);
    assign frame_ok  = ~bad_acc & ~line_bad & v_match;
    assign lock_cnt_inc = lock_cnt + 1'b1;

    always_comb begin
        state_next    = state;
        lock_cnt_next = lock_cnt;
        unique case (state)
            S_SEARCH: begin
                if (frame_start) begin
                    state_next    = S_TRACK;
                    lock_cnt_next = '0;
                end
            end
            S_TRACK: begin
                if (frame_start) begin
                    if (frame_ok) begin
                        lock_cnt_next = lock_cnt_inc;
                        if (lock_cnt_inc == LCW'(LOCK_FRAMES)) begin
                            state_next = S_LOCKED;
                        end
                    end else begin
                        lock_cnt_next = '0;
                    end
                end
            end
            S_LOCKED: begin
                if (line_bad || (frame_start && !frame_ok) || h_sat || v_sat) begin
                    state_next = S_SEARCH;
                end
            end
            default: begin
                state_next    = S_SEARCH;
                lock_cnt_next = '0;
            end
        endcase
        if (h_pol_change || v_pol_change) begin
            state_next = S_SEARCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_SEARCH;
            lock_cnt <= '0;
        end else begin
            state    <= state_next;
            lock_cnt <= lock_cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vs_pend   <= 1'b0;
            h_total   <= '0;
            v_total   <= '0;
            bad_acc   <= 1'b0;
            ref_valid <= 1'b0;
        end else begin
            if (hs_fall) begin
                vs_pend <= 1'b0;
                h_total <= h_pos_inc;
            end else if (vs_fall) begin
                vs_pend <= 1'b1;
            end

            if (frame_start) begin
                v_total <= v_pos_inc;
                bad_acc <= 1'b0;
            end else if (line_bad) begin
                bad_acc <= 1'b1;
            end

            if (state == S_SEARCH) begin
                ref_valid <= 1'b0;
            end else if (frame_start) begin
                ref_valid <= 1'b1;
            end
        end
    end

    assign locked = (state == S_LOCKED);

    assign in_window = locked
                     && (h_pos >= CW'(H_START)) && (h_pos < CW'(H_START + H_ACTIVE))
                     && (v_pos >= CW'(V_START)) && (v_pos < CW'(V_START + V_ACTIVE));

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            x      <= '0;
            y      <= '0;
        end else begin
            active <= in_window;
            x      <= in_window ? (h_pos - CW'(H_START)) : '0;
            y      <= in_window ? (v_pos - CW'(V_START)) : '0;
        end
    end

endmodule
